// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8 data bits, LSB first, 1 or 2 stop bits.
// tx_pin and tx_busy are registered from the current state, so both trail the FSM by one clock.
module uart_tx_fifo #(
   parameter int CLK        = 200_000_000,
   parameter int BPS        = 115200,
   parameter int FIFO_DEPTH = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx_pin,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int BPS_CNT = CLK / BPS;
   localparam int CW      = $clog2(BPS_CNT);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int LW      = AW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] level_q, level_d;
   logic          pin_q, pin_d, busy_q, busy_d;
   logic          push, pop, wrap;

   assign tx_ready   = level_q != LW'(FIFO_DEPTH);
   assign tx_pin     = pin_q;
   assign tx_busy    = busy_q;
   assign fifo_level = level_q;

   always_comb begin
      push    = tx_valid && tx_ready;
      wrap    = baud_q == CW'(BPS_CNT - 1);
      pop     = 1'b0;
      state_d = state_q;
      baud_d  = (state_q == IDLE || wrap) ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         IDLE:  pop = level_q != '0;
         START: if (wrap) begin
            state_d = DATA;
            bit_d   = '0;
         end
         DATA:  if (wrap) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            state_d = bit_q == 3'd7 ? STOP : DATA;
         end
         STOP:  if (wrap) begin
            if (bit_q == 3'(STOP_BITS - 1)) begin
               pop     = level_q != '0;
               state_d = IDLE;
               bit_d   = '0;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // a pop from STOP chains straight into the next start bit with no idle gap
      if (pop) begin
         state_d = START;
         shift_d = mem_q[rd_q];
         baud_d  = '0;
      end
      wr_d    = wr_q + AW'(push);
      rd_d    = rd_q + AW'(pop);
      level_d = level_q + LW'(push) - LW'(pop);
      pin_d   = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
      busy_d  = state_q != IDLE || level_q != '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         pin_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
         pin_q   <= pin_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= tx_data;
   end
endmodule
